// File: rtl/m_spi_arbiter_pkg.sv
// Shared definitions for the SPI requester arbiter: SPI IP register map,
// STATUS bit positions, controller state encodings and the default CONTROL value.
package m_spi_arbiter_pkg;

  // SPI IP register addresses
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;
  localparam logic [2:0] ADDR_SSMASK  = 3'd4;

  // STATUS bits: 4 and 5 together mean the transmitter can take a byte,
  // 6 means a received byte is waiting
  localparam int STAT_TMT_BIT  = 4;
  localparam int STAT_TRDY_BIT = 5;
  localparam int STAT_RRDY_BIT = 6;

  localparam logic [7:0] CTRL_ON_DEFAULT = 8'h8B;
  localparam logic [7:0] CTRL_OFF        = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ARB, ST_WR_SS, ST_WR_CTL, ST_POLL_TX,
    ST_WR_TX, ST_POLL_RX, ST_RD_RX, ST_WR_OFF, ST_DONE
  } arb_state_t;

  typedef enum logic [2:0] {
    RIO_IDLE, RIO_W1, RIO_W2, RIO_R1, RIO_R2, RIO_R3, RIO_R4
  } rio_state_t;

  // Slave-select mask with only the granted requester's bit set
  function automatic logic [7:0] ss_mask(input logic [2:0] idx);
    ss_mask = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/m_spi_arbiter_if.sv
// Register-access bus between the arbiter and the SPI IP.
interface m_spi_arbiter_if;
  logic       tx_en;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       rx_en;
  logic [2:0] raddr;
  logic [7:0] rdata;

  modport master (output tx_en, waddr, wdata, rx_en, raddr, input rdata);
  modport slave  (input tx_en, waddr, wdata, rx_en, raddr, output rdata);
endinterface

// File: rtl/m_spi_arbiter_regio.sv
// m_spi_regio: sequences one SPI IP register access per start pulse.
// Write: strobe cycle, then idle cycle. Read: strobe, wait, sample, evaluate.
// busy is high from the cycle after start until the access has finished.
module m_spi_regio
  import m_spi_arbiter_pkg::*;
(
  input  logic            I_CLK,
  input  logic            I_RESETN,
  input  logic            start,
  input  logic            is_write,
  input  logic [2:0]      addr,
  input  logic [7:0]      wdata,
  output logic            busy,
  output logic [7:0]      rdata,
  m_spi_arbiter_if.master bus
);

  rio_state_t state_reg, state_next;
  logic [2:0] addr_reg;
  logic [7:0] wdata_reg;
  logic [7:0] rdata_reg;

  // access sequencer state register
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) state_reg <= RIO_IDLE;
    else           state_reg <= state_next;
  end

  // fixed-length walk through the write or read cycle sequence
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RIO_IDLE: if (start) state_next = is_write ? RIO_W1 : RIO_R1;
      RIO_W1:   state_next = RIO_W2;
      RIO_W2:   state_next = RIO_IDLE;
      RIO_R1:   state_next = RIO_R2;
      RIO_R2:   state_next = RIO_R3;
      RIO_R3:   state_next = RIO_R4;
      RIO_R4:   state_next = RIO_IDLE;
      default:  state_next = RIO_IDLE;
    endcase
  end

  // capture the command on start and the read data on the sample cycle
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (state_reg == RIO_IDLE && start) begin
        addr_reg  <= addr;
        wdata_reg <= wdata;
      end
      if (state_reg == RIO_R3) rdata_reg <= bus.rdata;
    end
  end

  // address/data are only presented alongside their strobe, zero otherwise
  assign bus.tx_en = (state_reg == RIO_W1);
  assign bus.waddr = bus.tx_en ? addr_reg  : 3'd0;
  assign bus.wdata = bus.tx_en ? wdata_reg : 8'd0;
  assign bus.rx_en = (state_reg == RIO_R1);
  assign bus.raddr = bus.rx_en ? addr_reg  : 3'd0;
  assign busy      = (state_reg != RIO_IDLE);
  assign rdata     = rdata_reg;

endmodule

// File: rtl/m_spi_arbiter.sv
// m_spi_arbiter: round-robin arbiter that runs one complete SPI byte
// transfer (select, enable, poll, send, poll, receive, disable) per grant.
// Optional macro SPI_ARB_TIMEOUT_EN bounds each poll loop to 255 reads and
// adds the err output, high during the done pulse of a timed-out transfer.
module m_spi_arbiter
  import m_spi_arbiter_pkg::*;
#(
  parameter int         NREQ    = 4,
  parameter logic [7:0] CTRL_ON = CTRL_ON_DEFAULT
) (
  input  logic              I_CLK,
  input  logic              I_RESETN,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx_data,
  output logic              O_TX_EN,
  output logic [2:0]        O_WADDR,
  output logic [7:0]        O_WDATA,
  output logic              O_RX_EN,
  output logic [2:0]        O_RADDR,
`ifdef SPI_ARB_TIMEOUT_EN
  output logic              err,
`endif
  input  logic [7:0]        I_RDATA
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state_reg, state_next;
  logic [IW-1:0]   ptr_reg, idx_reg, arb_idx, cand;
  logic [NREQ-1:0] gnt_reg;
  logic [7:0]      tx_byte_reg, rx_data_reg;
  logic            issued_reg, issued_next;
  logic            arb_found, bus_state, step_done, poll_to, tx_ok, rx_ok;
  logic            io_start, io_write, io_busy;
  logic [2:0]      io_addr;
  logic [7:0]      io_wdata, io_rdata;
  logic [7:0]      req_byte [NREQ];

  m_spi_arbiter_if spi_bus ();

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  // round-robin search starting one past the last served requester
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_reg;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_reg) + k) % NREQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign tx_ok = io_rdata[STAT_TRDY_BIT] && io_rdata[STAT_TMT_BIT];
  assign rx_ok = io_rdata[STAT_RRDY_BIT];

  // transfer sequencing: each bus state issues one access and advances when it ends
  always_comb begin
    state_next = state_reg;
    io_write   = 1'b0;
    io_addr    = ADDR_RXDATA;
    io_wdata   = 8'h00;
    bus_state  = 1'b1;
    step_done  = issued_reg && !io_busy;
    case (state_reg)
      ST_IDLE: begin
        bus_state = 1'b0;
        if (|req) state_next = ST_ARB;
      end
      ST_ARB: begin
        bus_state  = 1'b0;
        state_next = arb_found ? ST_WR_SS : ST_IDLE;
      end
      ST_WR_SS: begin
        io_write = 1'b1;
        io_addr  = ADDR_SSMASK;
        io_wdata = ss_mask(3'(idx_reg));
        if (step_done) state_next = ST_WR_CTL;
      end
      ST_WR_CTL: begin
        io_write = 1'b1;
        io_addr  = ADDR_CONTROL;
        io_wdata = CTRL_ON;
        if (step_done) state_next = ST_POLL_TX;
      end
      ST_POLL_TX: begin
        io_addr = ADDR_STATUS;
        if (step_done) begin
          if (tx_ok)        state_next = ST_WR_TX;
          else if (poll_to) state_next = ST_WR_OFF;
        end
      end
      ST_WR_TX: begin
        io_write = 1'b1;
        io_addr  = ADDR_TXDATA;
        io_wdata = tx_byte_reg;
        if (step_done) state_next = ST_POLL_RX;
      end
      ST_POLL_RX: begin
        io_addr = ADDR_STATUS;
        if (step_done) begin
          if (rx_ok)        state_next = ST_RD_RX;
          else if (poll_to) state_next = ST_WR_OFF;
        end
      end
      ST_RD_RX: begin
        io_addr = ADDR_RXDATA;
        if (step_done) state_next = ST_WR_OFF;
      end
      ST_WR_OFF: begin
        io_write = 1'b1;
        io_addr  = ADDR_CONTROL;
        io_wdata = CTRL_OFF;
        if (step_done) state_next = ST_DONE;
      end
      ST_DONE: begin
        bus_state  = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        bus_state  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
    io_start    = bus_state && !issued_reg;
    issued_next = bus_state && !step_done;
  end

  // controller state, grant bookkeeping and data capture
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      state_reg   <= ST_IDLE;
      issued_reg  <= 1'b0;
      ptr_reg     <= IW'(NREQ - 1);
      idx_reg     <= '0;
      gnt_reg     <= '0;
      tx_byte_reg <= '0;
      rx_data_reg <= '0;
    end else begin
      state_reg  <= state_next;
      issued_reg <= issued_next;
      if (state_reg == ST_ARB && arb_found) begin
        idx_reg     <= arb_idx;
        gnt_reg     <= NREQ'(1) << arb_idx;
        tx_byte_reg <= req_byte[arb_idx];
      end
      if (state_reg == ST_RD_RX && step_done) rx_data_reg <= io_rdata;
      if (state_reg == ST_DONE) begin
        gnt_reg <= '0;
        ptr_reg <= idx_reg;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [7:0] poll_cnt_reg;
  logic       err_reg;
  logic       poll_miss;

  assign poll_miss = step_done && ((state_reg == ST_POLL_TX && !tx_ok) ||
                                   (state_reg == ST_POLL_RX && !rx_ok));
  // the 255th consecutive miss is the one seen with 254 already counted
  assign poll_to   = (poll_cnt_reg == 8'd254);

  // count consecutive failed polls; a timeout marks the transfer as errored
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      poll_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == ST_ARB) err_reg <= 1'b0;
      if (poll_miss) begin
        if (poll_to) begin
          poll_cnt_reg <= '0;
          err_reg      <= 1'b1;
        end else begin
          poll_cnt_reg <= poll_cnt_reg + 8'd1;
        end
      end else if (step_done) begin
        poll_cnt_reg <= '0;
      end
    end
  end

  assign err = err_reg && (state_reg == ST_DONE);
`else
  assign poll_to = 1'b0;
`endif

  m_spi_regio u_regio (
    .I_CLK    (I_CLK),
    .I_RESETN (I_RESETN),
    .start    (io_start),
    .is_write (io_write),
    .addr     (io_addr),
    .wdata    (io_wdata),
    .busy     (io_busy),
    .rdata    (io_rdata),
    .bus      (spi_bus)
  );

  assign spi_bus.rdata = I_RDATA;
  assign O_TX_EN       = spi_bus.tx_en;
  assign O_WADDR       = spi_bus.waddr;
  assign O_WDATA       = spi_bus.wdata;
  assign O_RX_EN       = spi_bus.rx_en;
  assign O_RADDR       = spi_bus.raddr;
  assign gnt           = gnt_reg;
  assign done          = (state_reg == ST_DONE) ? gnt_reg : '0;
  assign rx_data       = rx_data_reg;

endmodule

// File: tb/tb_m_spi_arbiter.sv
// Directed bench for m_spi_arbiter with a behavioural SPI IP register model.
module tb_m_spi_arbiter;
  import m_spi_arbiter_pkg::*;

  localparam int NREQ = 4;

  logic            I_CLK = 1'b0;
  logic            I_RESETN = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [31:0]     req_data = '0;
  logic [NREQ-1:0] gnt, done;
  logic [7:0]      rx_data;
`ifdef SPI_ARB_TIMEOUT_EN
  logic            err;
`endif

  m_spi_arbiter_if sbus ();

  m_spi_arbiter dut (
    .I_CLK    (I_CLK),
    .I_RESETN (I_RESETN),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .rx_data  (rx_data),
    .O_TX_EN  (sbus.tx_en),
    .O_WADDR  (sbus.waddr),
    .O_WDATA  (sbus.wdata),
    .O_RX_EN  (sbus.rx_en),
    .O_RADDR  (sbus.raddr),
`ifdef SPI_ARB_TIMEOUT_EN
    .err      (err),
`endif
    .I_RDATA  (sbus.rdata)
  );

  always #5 I_CLK = ~I_CLK;

  int          n_cmp = 0, n_bad = 0;
  int          tx_stall = 0, rx_stall = 0, status_reads = 0, status_at_tx = 0;
  logic        stuck = 1'b0, tx_seen = 1'b0;
  logic [7:0]  rx_val = 8'h00;
  logic [10:0] wr_q[$];
  int          done_q[$];
  logic        err_q[$];

  // SPI IP model: logs writes, answers reads (data appears after the read strobe)
  always @(negedge I_CLK) begin
    if (sbus.tx_en) begin
      wr_q.push_back({sbus.waddr, sbus.wdata});
      $display("%0t write addr=%0d data=%02h", $time, sbus.waddr, sbus.wdata);
      if (sbus.waddr == ADDR_CONTROL && sbus.wdata == CTRL_ON_DEFAULT) tx_seen = 1'b0;
      if (sbus.waddr == ADDR_TXDATA) begin
        tx_seen      = 1'b1;
        status_at_tx = status_reads;
      end
    end
    if (sbus.rx_en) begin
      if (sbus.raddr == ADDR_STATUS) begin
        status_reads++;
        if (stuck) sbus.rdata = 8'h00;
        else if (!tx_seen) begin
          if (tx_stall > 0) begin tx_stall--; sbus.rdata = 8'h00; end
          else sbus.rdata = 8'h30;
        end else begin
          if (rx_stall > 0) begin rx_stall--; sbus.rdata = 8'h30; end
          else sbus.rdata = 8'h70;
        end
      end else if (sbus.raddr == ADDR_RXDATA) sbus.rdata = rx_val;
      else sbus.rdata = 8'h00;
      $display("%0t read  addr=%0d data=%02h", $time, sbus.raddr, sbus.rdata);
    end
    if (|done) begin
      for (int k = 0; k < NREQ; k++) if (done[k]) done_q.push_back(k);
`ifdef SPI_ARB_TIMEOUT_EN
      err_q.push_back(err);
`endif
      $display("%0t done  mask=%b rx_data=%02h", $time, done, rx_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge I_CLK);
      if (|done) seen = 1'b1;
    end
    check("done_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic wait_tx(input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge I_CLK);
      if (tx_seen) seen = 1'b1;
    end
    check("txdata_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge I_CLK);
    I_RESETN = 1'b0;
    repeat (2) @(negedge I_CLK);
    I_RESETN = 1'b1;
    @(negedge I_CLK);
  endtask

  task automatic clear_logs();
    wr_q.delete();
    done_q.delete();
    err_q.delete();
    status_reads = 0;
    tx_seen = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},   32'(gnt), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_rxd"},   32'(rx_data), 32'd0);
    check({tag, "_txen"},  32'(sbus.tx_en), 32'd0);
    check({tag, "_rxen"},  32'(sbus.rx_en), 32'd0);
    check({tag, "_waddr"}, 32'(sbus.waddr), 32'd0);
    check({tag, "_raddr"}, 32'(sbus.raddr), 32'd0);
    check({tag, "_wdata"}, 32'(sbus.wdata), 32'd0);
  endtask

  int         exp_ord[5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_ss[5]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};
  logic [7:0] exp_tx[5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [7:0] ss_l[$], tx_l[$];

  initial begin
    sbus.rdata = 8'h00;
    // reset state
    repeat (2) @(negedge I_CLK);
    check_outputs_zero("reset");
    I_RESETN = 1'b1;
    @(negedge I_CLK);

    // single transfer on requester 0
    clear_logs();
    rx_val = 8'h3C;
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    wait_done(400);
    req = 4'b0000;
    repeat (4) @(negedge I_CLK);
    check("t1_nwr",  32'(wr_q.size()), 32'd4);
    check("t1_ss",   32'(wr_q[0]), {21'd0, ADDR_SSMASK, 8'h01});
    check("t1_ctl",  32'(wr_q[1]), {21'd0, ADDR_CONTROL, 8'h8B});
    check("t1_tx",   32'(wr_q[2]), {21'd0, ADDR_TXDATA, 8'hA5});
    check("t1_off",  32'(wr_q[3]), {21'd0, ADDR_CONTROL, 8'h00});
    check("t1_ndone", 32'(done_q.size()), 32'd1);
    check("t1_didx", 32'(done_q[0]), 32'd0);
    check("t1_rxd",  32'(rx_data), 32'h3C);
    check("t1_gnt",  32'(gnt), 32'd0);

    // all four requesting: round-robin order 0,1,2,3,0
    do_reset();
    clear_logs();
    rx_val = 8'h5E;
    req_data = 32'h44332211;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_done(400);
    req = 4'b0000;
    repeat (4) @(negedge I_CLK);
    foreach (wr_q[i]) begin
      if (wr_q[i][10:8] == ADDR_SSMASK) ss_l.push_back(wr_q[i][7:0]);
      if (wr_q[i][10:8] == ADDR_TXDATA) tx_l.push_back(wr_q[i][7:0]);
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_order%0d", i), 32'(done_q[i]), 32'(exp_ord[i]));
      check($sformatf("rr_ss%0d", i), 32'(ss_l[i]), 32'(exp_ss[i]));
      check($sformatf("rr_tx%0d", i), 32'(tx_l[i]), 32'(exp_tx[i]));
    end

    // transmitter busy for 10 reads: no TXDATA write until ready
    clear_logs();
    tx_stall = 10;
    req_data[15:8] = 8'h5A;
    req = 4'b0010;
    wait_done(600);
    req = 4'b0000;
    repeat (4) @(negedge I_CLK);
    check("stall_reads_before_tx", 32'(status_at_tx), 32'd11);
    check("stall_reads_total", 32'(status_reads), 32'd12);
    check("stall_tx", 32'(wr_q[2]), {21'd0, ADDR_TXDATA, 8'h5A});
    check("stall_didx", 32'(done_q[0]), 32'd1);

    // drop request and change data during the receive poll
    clear_logs();
    rx_stall = 5;
    req_data[23:16] = 8'hC7;
    req = 4'b0100;
    wait_tx(300);
    repeat (6) @(negedge I_CLK);
    req = 4'b0000;
    req_data = 32'h0;
    @(negedge I_CLK);
    check("drop_gnt_held", 32'(gnt), 32'h4);
    wait_done(400);
    repeat (4) @(negedge I_CLK);
    check("drop_ndone", 32'(done_q.size()), 32'd1);
    check("drop_didx", 32'(done_q[0]), 32'd2);
    check("drop_tx", 32'(wr_q[2]), {21'd0, ADDR_TXDATA, 8'hC7});

    // reset in the middle of the receive poll
    clear_logs();
    rx_stall = 20;
    req_data[7:0] = 8'h66;
    req = 4'b0001;
    wait_tx(300);
    repeat (8) @(negedge I_CLK);
    I_RESETN = 1'b0;
    #1;
    check_outputs_zero("midrst");
    req = 4'b0000;
    rx_stall = 0;
    repeat (2) @(negedge I_CLK);
    I_RESETN = 1'b1;
    repeat (5) @(negedge I_CLK);
    check("midrst_no_done", 32'(done_q.size()), 32'd0);
    clear_logs();
    req = 4'b1100;
    wait_done(400);
    req = 4'b0000;
    repeat (4) @(negedge I_CLK);
    check("postrst_didx", 32'(done_q[0]), 32'd2);
    check("postrst_ss", 32'(wr_q[0]), {21'd0, ADDR_SSMASK, 8'h04});

`ifdef SPI_ARB_TIMEOUT_EN
    // STATUS stuck at zero: 255 reads then CONTROL off and an errored done
    do_reset();
    clear_logs();
    stuck = 1'b1;
    req = 4'b0001;
    wait_done(4000);
    req = 4'b0000;
    stuck = 1'b0;
    repeat (4) @(negedge I_CLK);
    check("to_reads", 32'(status_reads), 32'd255);
    check("to_off", 32'(wr_q[wr_q.size()-1]), {21'd0, ADDR_CONTROL, 8'h00});
    check("to_err", 32'(err_q[0]), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m_spi_arbiter.md
M_SPI_ARBITER -- requirements
Module: m_spi_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (fixed 4 in this release).
REQ-002 SHALL have parameter CTRL_ON, default 8'h8B, CONTROL value written to start a transfer.
REQ-003 SHALL have port I_CLK, input, 1, the single clock; all logic rises on posedge.
REQ-004 SHALL have port I_RESETN, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, NREQ, per-requester transfer request level.
REQ-006 SHALL have port req_data, input, 8*NREQ, TX byte per requester (slice i = bits 8i+7:8i).
REQ-007 SHALL have port gnt, output, NREQ, one-hot grant, held for the whole transfer.
REQ-008 SHALL have port done, output, NREQ, one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port rx_data, output, 8, byte received in the last completed transfer.
REQ-010 SHALL have ports O_TX_EN (out,1), O_WADDR (out,3), O_WDATA (out,8): SPI IP register write strobe, address, data.
REQ-011 SHALL have ports O_RX_EN (out,1), O_RADDR (out,3), I_RDATA (in,8): SPI IP register read strobe, address, data.

Function
REQ-012 SHALL use register addresses RXDATA=0, TXDATA=1, STATUS=2, CONTROL=3, SSMASK=4.
REQ-013 SHALL perform a register write as two cycles: O_TX_EN=1 with addr/data, then O_TX_EN=0.
REQ-014 SHALL perform a register read as four cycles: O_RX_EN=1 with addr; O_RX_EN=0; sample I_RDATA; evaluate.
REQ-015 SHALL implement states IDLE, ARB, WR_SS, WR_CTL, POLL_TX, WR_TX, POLL_RX, RD_RX, WR_OFF, DONE.
REQ-016 IDLE: if any req bit set, go to ARB next cycle; otherwise stay.
REQ-017 ARB: pick round-robin starting at ptr+1 (mod NREQ), assert its gnt, latch its req_data, go to WR_SS.
REQ-018 WR_SS SHALL write SSMASK = one-hot of granted index (bits 7:NREQ zero).
REQ-019 WR_CTL SHALL write CONTROL = CTRL_ON.
REQ-020 POLL_TX SHALL read STATUS, repeating until bits 5 and 4 both 1, then go WR_TX.
REQ-021 WR_TX SHALL write TXDATA = latched byte.
REQ-022 POLL_RX SHALL read STATUS, repeating until bit 6 is 1, then go RD_RX.
REQ-023 RD_RX SHALL read RXDATA and load rx_data on the sample cycle.
REQ-024 WR_OFF SHALL write CONTROL = 8'h00.
REQ-025 DONE SHALL pulse done[granted] for one cycle, drop gnt, set ptr = granted index, return to IDLE.
REQ-026 Deasserting req mid-transfer SHALL NOT abort; transfer completes and done still pulses.
REQ-027 req_data changes after ARB SHALL NOT affect the byte sent.
REQ-028 O_TX_EN and O_RX_EN SHALL never be high in the same cycle.
REQ-029 A requester held high continuously SHALL be re-granted only after all other pending requesters are served.

Reset
REQ-030 On I_RESETN low, immediately: state IDLE, ptr=NREQ-1, gnt=0, done=0, rx_data=0, O_TX_EN=0, O_RX_EN=0, O_WADDR=0, O_RADDR=0, O_WDATA=0.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no done pulse; first grant after reset goes to lowest pending index.

Configuration
REQ-032 Macro SPI_ARB_TIMEOUT_EN defined: each POLL state counts reads; at 255 unsuccessful reads go to WR_OFF, then DONE with output err (out,1) high during the done pulse.
REQ-033 Macro undefined: no counter, no err port, polls unbounded.

Structure
REQ-034 Shared package SHALL hold register addresses, STATUS bit positions (4,5,6), state encoding, CTRL_ON default.
REQ-035 Sub-module m_spi_regio SHALL implement the 2-cycle write / 4-cycle read bus sequencing with start/busy/rdata handshake.

Verification
REQ-036 Reset then req=4'b0001, data 8'hA5, model STATUS=8'h30 then 8'h70, RXDATA=8'h3C -> SSMASK 8'h01, CONTROL 8'h8B, TXDATA 8'hA5, CONTROL 8'h00, done[0] once, rx_data=8'h3C.
REQ-037 req=4'b1111 held -> grant order 0,1,2,3,0 with SSMASK 01,02,04,08,01.
REQ-038 STATUS bits5:4=0 for 10 reads -> exactly 10 extra STATUS reads, no TXDATA write before bits set.
REQ-039 Drop req[2] and change req_data during POLL_RX -> done[2] still pulses, TXDATA equals originally latched byte.
REQ-040 Assert I_RESETN low during POLL_RX -> all outputs zero same cycle, no done; after release req=4'b0100 granted first.
REQ-041 With SPI_ARB_TIMEOUT_EN, STATUS stuck 8'h00 -> 255 reads, CONTROL 8'h00 write, done with err=1.
